// File: rtl/redirect_pkg.sv
// Shared types for the PC redirect arbiter: source codes, FSM states and
// the priority-compare helper used when a pending redirect may be replaced.
package redirect_pkg;

   localparam int NUM_SRC = 5;
   localparam int PC_W    = 32;

   // Numeric order doubles as priority order: a lower nonzero code wins.
   typedef enum logic [2:0] {
      SRC_NONE   = 3'd0,
      SRC_ERA    = 3'd1,
      SRC_EENTRY = 3'd2,
      SRC_CSR    = 3'd3,
      SRC_EX     = 3'd4,
      SRC_PD     = 3'd5
   } redir_src_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_DRAIN = 2'd2
   } redir_state_e;

   // True when source a has priority higher than or equal to source b.
   function automatic logic src_ge(input redir_src_e a, input redir_src_e b);
      return (a != SRC_NONE) && (a <= b);
   endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority selector over the redirect sources (index 0 = highest).
// Produces the winning source code and its target PC, purely combinational.
module redirect_prio_enc
   import redirect_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [PC_W-1:0]    pc [NUM_SRC],
   output logic               win_valid,
   output redir_src_e         win_src,
   output logic [PC_W-1:0]    win_pc
);

   logic [NUM_SRC-1:0] higher;
   logic [NUM_SRC-1:0] grant;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_grant
         if (gi == 0) begin : g_top
            assign higher[gi] = 1'b0;
         end else begin : g_rest
            assign higher[gi] = |req[gi-1:0];
         end
         assign grant[gi] = req[gi] & ~higher[gi];
      end
   endgenerate

   // grant is one-hot, so OR-ing the selected PCs is a clean mux.
   always_comb begin
      win_valid = |req;
      win_src   = SRC_NONE;
      win_pc    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            win_src = redir_src_e'(3'(i + 1));
            win_pc  = win_pc | pc[i];
         end
      end
   end

endmodule

// File: rtl/pc_redirect_arb.sv
// PC redirect arbiter: picks the highest-priority redirect, offers it to fetch
// until accepted, bumps the fetch epoch and drains the front end afterwards.
// Optional statistics counters are enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_arb
   import redirect_pkg::*;
#(
   parameter int FLUSH_CYC = 1
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        era_req,
   input  logic [31:0] era_pc,
   input  logic        eentry_req,
   input  logic [31:0] eentry_pc,
   input  logic        csr_req,
   input  logic [31:0] csr_pc,
   input  logic        ex_req,
   input  logic [31:0] ex_pc,
   input  logic        pd_req,
   input  logic [31:0] pd_pc,
   input  logic        fetch_ready,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   output logic [2:0]  redir_src,
   output logic        flush_front,
   output logic [1:0]  epoch,
   output logic [31:0] stat_redir_cnt,
   output logic [31:0] stat_pd_cnt
);

   localparam logic [2:0] DRAIN_LAST = (FLUSH_CYC > 0) ? 3'(FLUSH_CYC - 1) : 3'd0;

   logic [NUM_SRC-1:0] req_vec;
   logic [PC_W-1:0]    pc_vec [NUM_SRC];
   logic               win_valid;
   redir_src_e         win_src;
   logic [PC_W-1:0]    win_pc;

   redir_state_e       state_reg, state_next;
   logic [PC_W-1:0]    pc_reg, pc_next;
   redir_src_e         src_reg, src_next;
   logic [1:0]         epoch_reg;
   logic [2:0]         drain_cnt_reg, drain_cnt_next;
   logic               handshake;
   logic               load_win;

   assign req_vec   = {pd_req, ex_req, csr_req, eentry_req, era_req};
   assign pc_vec[0] = era_pc;
   assign pc_vec[1] = eentry_pc;
   assign pc_vec[2] = csr_pc;
   assign pc_vec[3] = ex_pc;
   assign pc_vec[4] = pd_pc;

   redirect_prio_enc u_prio_enc (
      .req       (req_vec),
      .pc        (pc_vec),
      .win_valid (win_valid),
      .win_src   (win_src),
      .win_pc    (win_pc)
   );

   assign handshake = (state_reg == ST_PEND) && fetch_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (win_valid) state_next = ST_PEND;
         end
         ST_PEND: begin
            if (handshake) begin
               if (win_valid)          state_next = ST_PEND;
               else if (FLUSH_CYC > 0) state_next = ST_DRAIN;
               else                    state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (win_valid)                        state_next = ST_PEND;
            else if (drain_cnt_reg == DRAIN_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      redir_valid = (state_reg == ST_PEND);
      flush_front = (state_reg != ST_IDLE);
      redir_pc    = redir_valid ? pc_reg : '0;
      redir_src   = redir_valid ? src_reg : SRC_NONE;
      epoch       = epoch_reg;
   end

   // While stalled only an equal-or-better source may overwrite the offer;
   // once fetch accepts, whatever arrives that cycle becomes the next offer.
   always_comb begin
      load_win = 1'b0;
      case (state_reg)
         ST_PEND: load_win = win_valid && (handshake || src_ge(win_src, src_reg));
         default: load_win = win_valid;
      endcase
      pc_next  = pc_reg;
      src_next = src_reg;
      if (load_win) begin
         pc_next  = win_pc;
         src_next = win_src;
      end else if (state_next != ST_PEND) begin
         pc_next  = '0;
         src_next = SRC_NONE;
      end
      drain_cnt_next = (state_reg == ST_DRAIN) ? drain_cnt_reg + 3'd1 : 3'd0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_reg        <= '0;
         src_reg       <= SRC_NONE;
         epoch_reg     <= 2'd0;
         drain_cnt_reg <= 3'd0;
      end else begin
         pc_reg        <= pc_next;
         src_reg       <= src_next;
         drain_cnt_reg <= drain_cnt_next;
         if (handshake) epoch_reg <= epoch_reg + 2'd1;
      end
   end

`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] stat_redir_reg;
   logic [31:0] stat_pd_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_redir_reg <= '0;
         stat_pd_reg    <= '0;
      end else if (handshake) begin
         if (stat_redir_reg != 32'hFFFF_FFFF) stat_redir_reg <= stat_redir_reg + 32'd1;
         if (src_reg == SRC_PD && stat_pd_reg != 32'hFFFF_FFFF) stat_pd_reg <= stat_pd_reg + 32'd1;
      end
   end

   assign stat_redir_cnt = stat_redir_reg;
   assign stat_pd_cnt    = stat_pd_reg;
`else
   assign stat_redir_cnt = '0;
   assign stat_pd_cnt    = '0;
`endif

endmodule
